// File: rtl/isi_channel_sequencer_if.sv
// Control, symbol-source and channel-sample signals of the ISI channel sequencer.
// timeout_err exists only when ISI_SEQ_TIMEOUT_EN is defined.
interface isi_channel_sequencer_if #(
   parameter int SIGNAL_RESOLUTION = 8
);
   logic                                start;
   logic [31:0]                         num_symbols;
   logic [1:0]                          sym_in;
   logic                                sym_in_valid;
   logic                                sym_in_ready;
   logic signed [SIGNAL_RESOLUTION-1:0] ch_signal;
   logic                                ch_valid;
   logic                                busy;
   logic                                done;
   logic [31:0]                         sym_count;
`ifdef ISI_SEQ_TIMEOUT_EN
   logic                                timeout_err;
`endif

   modport master (
`ifdef ISI_SEQ_TIMEOUT_EN
      input  timeout_err,
`endif
      output start, num_symbols, sym_in, sym_in_valid,
      input  sym_in_ready, ch_signal, ch_valid, busy, done, sym_count
   );

   modport slave (
`ifdef ISI_SEQ_TIMEOUT_EN
      output timeout_err,
`endif
      input  start, num_symbols, sym_in, sym_in_valid,
      output sym_in_ready, ch_signal, ch_valid, busy, done, sym_count
   );
endinterface

// File: rtl/isi_channel_sequencer.sv
// Frames PAM-4 symbols for the ISI channel model between FLUSH/DRAIN zero runs, one sample per PACE_DIV clocks.
// Define ISI_SEQ_TIMEOUT_EN to add the source-stall timeout and the timeout_err flag.
module isi_channel_sequencer #(
   parameter int PULSE_RESPONSE_LENGTH = 2,
   parameter int SIGNAL_RESOLUTION     = 8,
   parameter int SYMBOL_SEPERATION     = 56,
   parameter int PACE_DIV              = 1,
   parameter int TIMEOUT_CYCLES        = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   isi_channel_sequencer_if.slave bus
);
   localparam int PW = (PACE_DIV > 1) ? $clog2(PACE_DIV) : 1;
   localparam logic [PW-1:0] PACE_LAST = PW'(PACE_DIV - 1);
   localparam int ZW = $clog2(PULSE_RESPONSE_LENGTH + 1);
   localparam logic [ZW-1:0] ZERO_LAST = ZW'(PULSE_RESPONSE_LENGTH - 1);

   typedef logic signed [SIGNAL_RESOLUTION-1:0] sample_t;
   typedef enum logic [2:0] {IDLE, FLUSH, RUN, DRAIN, DONE} state_t;

   if (PACE_DIV < 1) begin : g_bad_pace
      $error("PACE_DIV must be at least 1");
   end
   if ((SYMBOL_SEPERATION % 2) != 0) begin : g_bad_sep
      $error("SYMBOL_SEPERATION must be even");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   function automatic sample_t sat(input longint v);
      longint hi, lo;
      hi = (longint'(1) <<< (SIGNAL_RESOLUTION - 1)) - 1;
      lo = -hi - 1;
      if (v > hi)      sat = sample_t'(hi);
      else if (v < lo) sat = sample_t'(lo);
      else             sat = sample_t'(v);
   endfunction

   localparam longint HALF_S = longint'(SYMBOL_SEPERATION / 2);
   localparam sample_t LVL_N3 = sat(-3 * HALF_S);
   localparam sample_t LVL_N1 = sat(-HALF_S);
   localparam sample_t LVL_P1 = sat(HALF_S);
   localparam sample_t LVL_P3 = sat(3 * HALF_S);

   state_t        state;
   logic [PW-1:0] pace_cnt;
   logic [ZW-1:0] zero_cnt;
   logic [31:0]   remaining;
   logic          slot;
   logic          hs;
   sample_t       lvl;

`ifdef ISI_SEQ_TIMEOUT_EN
   localparam int SW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [SW-1:0] STALL_LAST = SW'(TIMEOUT_CYCLES - 1);
   logic [SW-1:0] stall_cnt;
`endif

   assign slot             = (pace_cnt == '0);
   // ready never looks at sym_in_valid, so the source may wait on it freely
   assign bus.sym_in_ready = (state == RUN) && slot && (remaining != 32'd0);
   assign hs               = bus.sym_in_valid && bus.sym_in_ready;

   always_comb begin
      lvl = LVL_P3;
      case (bus.sym_in)
         2'd0:    lvl = LVL_N3;
         2'd1:    lvl = LVL_N1;
         2'd2:    lvl = LVL_P1;
         default: lvl = LVL_P3;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         pace_cnt      <= '0;
         zero_cnt      <= '0;
         remaining     <= '0;
         bus.ch_signal <= '0;
         bus.ch_valid  <= 1'b0;
         bus.busy      <= 1'b0;
         bus.done      <= 1'b0;
         bus.sym_count <= '0;
`ifdef ISI_SEQ_TIMEOUT_EN
         stall_cnt       <= '0;
         bus.timeout_err <= 1'b0;
`endif
      end else begin
         bus.ch_valid <= 1'b0;
         bus.done     <= 1'b0;
         // pacing keeps running through source stalls so slot timing never drifts
         if (state == IDLE)            pace_cnt <= '0;
         else if (pace_cnt == PACE_LAST) pace_cnt <= '0;
         else                          pace_cnt <= pace_cnt + 1'b1;

         case (state)
            IDLE: begin
               if (bus.start) begin
                  remaining     <= bus.num_symbols;
                  bus.sym_count <= '0;
                  zero_cnt      <= '0;
                  bus.busy      <= 1'b1;
                  state         <= FLUSH;
`ifdef ISI_SEQ_TIMEOUT_EN
                  stall_cnt       <= '0;
                  bus.timeout_err <= 1'b0;
`endif
               end
            end
            FLUSH: begin
               if (slot) begin
                  bus.ch_signal <= '0;
                  bus.ch_valid  <= 1'b1;
                  if (zero_cnt == ZERO_LAST) begin
                     zero_cnt <= '0;
                     state    <= (remaining == 32'd0) ? DRAIN : RUN;
                  end else begin
                     zero_cnt <= zero_cnt + 1'b1;
                  end
               end
            end
            RUN: begin
               if (hs) begin
                  bus.ch_signal <= lvl;
                  bus.ch_valid  <= 1'b1;
                  bus.sym_count <= bus.sym_count + 32'd1;
                  remaining     <= remaining - 32'd1;
                  if (remaining == 32'd1) state <= DRAIN;
`ifdef ISI_SEQ_TIMEOUT_EN
                  stall_cnt <= '0;
               end else if (bus.sym_in_ready) begin
                  if (stall_cnt == STALL_LAST) begin
                     stall_cnt       <= '0;
                     bus.timeout_err <= 1'b1;
                     state           <= DRAIN;
                  end else begin
                     stall_cnt <= stall_cnt + 1'b1;
                  end
`endif
               end
            end
            DRAIN: begin
               if (slot) begin
                  bus.ch_signal <= '0;
                  bus.ch_valid  <= 1'b1;
                  if (zero_cnt == ZERO_LAST) begin
                     zero_cnt <= '0;
                     bus.done <= 1'b1;
                     state    <= DONE;
                  end else begin
                     zero_cnt <= zero_cnt + 1'b1;
                  end
               end
            end
            DONE: begin
               bus.busy <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
